alu_issuer: RTL

ALU_ISSUER -- requirements
Module: alu_issuer

---
 rtl/alu_issuer.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/alu_issuer.sv
// alu_issuer: buffers ALU commands, drives them with a settle delay, returns responses.
// Build option: define ALU_ISSUER_OPCHK_EN to reject opcode 3'b111 with rsp_err.
module alu_issuer #(
    parameter int SETTLE_CYC = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_op,
    input  logic [7:0] cmd_a,
    input  logic [7:0] cmd_b,
    output logic [7:0] alu_i_1,
    output logic [7:0] alu_i_2,
    output logic [2:0] alu_op_code,
    input  logic [7:0] alu_o_main,
    input  logic [1:0] alu_carry_out,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic [1:0] rsp_carry,
    output logic [2:0] rsp_op,
    output logic       rsp_err,
    output logic       busy
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        RESPOND
    } state_t;

    state_t         state;
    state_t         state_n;
    cmd_t           mem [FIFO_DEPTH];
    cmd_t           head;
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [CW-1:0]  count;
    logic [3:0]     cnt;
    logic           push;
    logic           pop;
    logic           issue;
    logic           capture;
    logic           reject;
    logic           fifo_empty;
    logic           head_bad;

    assign cmd_ready  = count < CW'(FIFO_DEPTH);
    assign fifo_empty = (count == '0);
    assign push       = cmd_valid & cmd_ready;
    assign head       = mem[rd_ptr];
    assign rsp_valid  = (state == RESPOND);
    assign busy       = (state != IDLE) | ~fifo_empty;

`ifdef ALU_ISSUER_OPCHK_EN
    assign head_bad = (head.op == 3'b111);
`else
    assign head_bad = 1'b0;
`endif

    // Command storage; contents need no reset, only the pointers do.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{op: cmd_op, a: cmd_a, b: cmd_b};
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state and per-cycle control strobes.
    always_comb begin
        state_n = state;
        pop     = 1'b0;
        issue   = 1'b0;
        capture = 1'b0;
        reject  = 1'b0;
        unique case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                    if (head_bad) begin
                        reject  = 1'b1;
                        state_n = RESPOND;
                    end else begin
                        issue   = 1'b1;
                        state_n = DRIVE;
                    end
                end
            end
            DRIVE: begin
                if (cnt == 4'd1) begin
                    capture = 1'b1;
                    state_n = RESPOND;
                end
            end
            RESPOND: begin
                if (rsp_ready) begin
                    if (!fifo_empty) begin
                        pop = 1'b1;
                        if (head_bad) begin
                            reject  = 1'b1;
                            state_n = RESPOND;
                        end else begin
                            issue   = 1'b1;
                            state_n = DRIVE;
                        end
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // ALU drive registers hold the last issued command between issues.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_i_1     <= '0;
            alu_i_2     <= '0;
            alu_op_code <= '0;
        end else if (issue) begin
            alu_i_1     <= head.a;
            alu_i_2     <= head.b;
            alu_op_code <= head.op;
        end
    end

    // Settle counter: loaded on issue, counts down while driving.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (issue) begin
            cnt <= 4'(SETTLE_CYC);
        end else if (state == DRIVE) begin
            cnt <= cnt - 4'd1;
        end
    end

    // Response registers, stable for the whole RESPOND phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_data  <= '0;
            rsp_carry <= '0;
            rsp_op    <= '0;
        end else if (capture) begin
            rsp_data  <= alu_o_main;
            rsp_carry <= alu_carry_out;
            rsp_op    <= alu_op_code;
        end else if (reject) begin
            rsp_data  <= '0;
            rsp_carry <= '0;
            rsp_op    <= head.op;
        end
    end

`ifdef ALU_ISSUER_OPCHK_EN
    // Error flag marks a rejected opcode for the response it belongs to.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_err <= 1'b0;
        end else if (capture) begin
            rsp_err <= 1'b0;
        end else if (reject) begin
            rsp_err <= 1'b1;
        end
    end
`else
    assign rsp_err = 1'b0;
`endif

endmodule
